// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver:
// hex glyph table, segment bit positions and polarity helper.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [6:0] seg_polarity(
    input logic [6:0] value,
    input bit         active_low
  );
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit code to active-high
// seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[code];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with
// frame-aligned updates and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PC_LAST =
    PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF =
    {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]           pc;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    fb;

  logic [4*NUM_DIGITS-1:0] disp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_v;

  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [3:0]              code;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    blank;
  logic [6:0]              raw_seg;
  logic [6:0]              lit_seg;

  assign tick = (pc == PC_LAST);
  assign fb   = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else begin
      pc <= tick ? '0 : pc + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // A load coinciding with the frame edge bypasses
  // the pending stage so it is never lost or delayed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp    <= '0;
      disp_dp <= '0;
      pend    <= '0;
      pend_dp <= '0;
      pend_v  <= 1'b0;
    end else if (fb && load_i) begin
      disp    <= digits_i;
      disp_dp <= dp_i;
      pend_v  <= 1'b0;
    end else begin
      if (load_i) begin
        pend    <= digits_i;
        pend_dp <= dp_i;
        pend_v  <= 1'b1;
      end
      if (fb && pend_v) begin
        disp    <= pend;
        disp_dp <= pend_dp;
        pend_v  <= 1'b0;
      end
    end
  end

  // lz[k]: display digits NUM_DIGITS-1 down to k all zero
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] =
      (disp[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz[k] = lz[k+1] && (disp[4*k +: 4] == 4'd0);
    end
  end

  always_comb begin
    code   = '0;
    cur_dp = 1'b0;
    cur_lz = 1'b0;
    an_hot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        code      = disp[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_lz    = lz[k];
        an_hot[k] = 1'b1;
      end
    end
  end

  assign blank =
    blank_lz_i && (idx != '0) && cur_lz;

  seg7_hex_decoder u_dec (
    .code (code),
    .seg  (raw_seg)
  );

  assign lit_seg = blank ? 7'b0 : raw_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_o        <= SEG_OFF;
      dp_o         <= SEG_ACTIVE_LOW;
      an_o         <= AN_OFF;
      frame_done_o <= 1'b0;
    end else begin
      seg_o <= seg_polarity(lit_seg, SEG_ACTIVE_LOW);
      dp_o  <= cur_dp ^ SEG_ACTIVE_LOW;
      an_o  <= an_hot ^ AN_OFF;
      frame_done_o <= fb;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected
// frames are queued by stimulus, checked per frame.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_done_o;

  seg7_scan_driver #(
    .NUM_DIGITS     (4),
    .PRESCALE       (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .load_i       (load_i),
    .blank_lz_i   (blank_lz_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // seg: slot k at [7k+:7], active-low; dp: active-low per slot
  typedef struct packed {
    logic [27:0] seg;
    logic [3:0]  dp;
  } frame_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  localparam logic [6:0] OFF = 7'b1111111;

  frame_t exp_q[$];
  int     n_err = 0;
  int     n_chk = 0;
  bit     mon_busy = 1'b0;

  function automatic logic [6:0] segn(input int v);
    return ~GLYPH[v];
  endfunction

  function automatic frame_t frm(
    input logic [6:0] s3, input logic [6:0] s2,
    input logic [6:0] s1, input logic [6:0] s0,
    input logic [3:0] dpn
  );
    return {s3, s2, s1, s0, dpn};
  endfunction

  function automatic frame_t mk_hex(
    input logic [15:0] d, input logic [3:0] dp
  );
    return frm(segn(int'(d[15:12])), segn(int'(d[11:8])),
               segn(int'(d[7:4])), segn(int'(d[3:0])), ~dp);
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] want
  );
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd();
    int t = 0;
    do begin
      step();
      t++;
    end while (!frame_done_o && t < 40);
    if (!frame_done_o) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 200) begin
      step();
      t++;
    end
    if (exp_q.size() != 0 || mon_busy)
      chk("scoreboard_timeout", 0, 1);
  endtask

  task automatic load_frame(
    input logic [15:0] d, input logic [3:0] dp,
    input logic bl, input frame_t e
  );
    blank_lz_i = bl;
    wait_fd();
    step();
    step();
    digits_i = d;
    dp_i     = dp;
    load_i   = 1'b1;
    exp_q.push_back(e);
    step();
    load_i = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reset_out(input string tag);
    chk({tag, "_an"}, an_o, 4'b1111);
    chk({tag, "_seg"}, seg_o, 7'b1111111);
    chk({tag, "_dp"}, dp_o, 1'b1);
    chk({tag, "_fd"}, frame_done_o, 1'b0);
  endtask

  // First frame after reset: digit 0 first, "0" everywhere
  task automatic chk_restart();
    logic [3:0] one = 4'b0001;
    logic [3:0] want_an;
    for (int j = 0; j < 8; j++) begin
      step();
      want_an = ~(one << (j / 2));
      chk("restart_an", an_o, want_an);
      chk("restart_seg", seg_o, 7'b1000000);
      chk("restart_dp", dp_o, 1'b1);
      chk("restart_fd", frame_done_o, j == 7);
    end
  endtask

  initial begin : monitor
    frame_t     cur;
    int         j;
    int         s;
    logic [3:0] one;
    logic [3:0] want_an;
    cur = '0;
    j   = 0;
    one = 4'b0001;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 1'b0;
      end else begin
        if (mon_busy) begin
          s = j / 2;
          want_an = ~(one << s);
          chk("scan_an", an_o, want_an);
          chk("scan_seg", seg_o, cur.seg[s*7 +: 7]);
          chk("scan_dp", dp_o, cur.dp[s]);
          chk("scan_fd", frame_done_o, j == 7);
          j++;
          if (j == 8) mon_busy = 1'b0;
        end
        if (!mon_busy && frame_done_o && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          mon_busy = 1'b1;
          j = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] nib;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_out("reset");
    end
    rst_n = 1'b1;
    chk_restart();

    for (int v = 0; v < 16; v++) begin
      nib = v[3:0];
      load_frame({4{nib}}, 4'b0000, 1'b0,
                 mk_hex({4{nib}}, 4'b0000));
    end

    // Old value must hold for the frame in which 0x1234 lands
    wait_idle();
    exp_q.push_back(mk_hex(16'hFFFF, 4'b0000));
    wait_fd();
    step();
    step();
    step();
    digits_i = 16'h1234;
    dp_i     = 4'b0000;
    load_i   = 1'b1;
    exp_q.push_back(mk_hex(16'h1234, 4'b0000));
    step();
    load_i = 1'b0;
    wait_idle();

    // Load lands exactly on the frame edge
    wait_fd();
    for (int i = 0; i < 7; i++) step();
    digits_i = 16'h9876;
    dp_i     = 4'b0001;
    load_i   = 1'b1;
    exp_q.push_back(mk_hex(16'h9876, 4'b0001));
    step();
    load_i = 1'b0;
    wait_idle();

    load_frame(16'h0050, 4'b0000, 1'b1,
               frm(OFF, OFF, 7'b0010010, 7'b1000000, 4'b1111));
    load_frame(16'h0000, 4'b0000, 1'b1,
               frm(OFF, OFF, OFF, 7'b1000000, 4'b1111));

    blank_lz_i = 1'b0;
    exp_q.push_back(frm(7'b1000000, 7'b1000000,
                        7'b1000000, 7'b1000000, 4'b1111));
    wait_idle();

    load_frame(16'h0005, 4'b0100, 1'b1,
               frm(OFF, OFF, OFF, 7'b0010010, 4'b1011));

    // Reset sampled while idx == 2
    blank_lz_i = 1'b0;
    wait_idle();
    wait_fd();
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    chk_reset_out("midreset");
    rst_n = 1'b1;
    chk_restart();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
